// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: state encodings and default geometry.
package mux_scan_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_DONE = ST_DONE
    } scan_state_t;

    localparam int DEF_SEL_W  = 3;
    localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bus between the scan sequencer and the board/mux side; parity member exists only
// when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_sequencer_if #(
    parameter int SEL_W = mux_scan_pkg::DEF_SEL_W
);
    localparam int N = 1 << SEL_W;

    logic             start;
    logic             mux_o;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N-1:0]     data_out;
`ifdef MUX_SCAN_PARITY_EN
    logic             parity;

    modport master (input start, input mux_o,
                    output sel, output busy, output done, output data_out, output parity);
    modport slave  (output start, output mux_o,
                    input sel, input busy, input done, input data_out, input parity);
`else
    modport master (input start, input mux_o,
                    output sel, output busy, output done, output data_out);
    modport slave  (output start, output mux_o,
                    input sel, input busy, input done, input data_out);
`endif

endinterface

// File: rtl/mux_scan_sequencer_settle_counter.sv
// Per-step settle timer: loads SETTLE-1, counts down to zero and flags zero.
module settle_counter #(
    parameter int SETTLE = mux_scan_pkg::DEF_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CNT_W = $clog2(SETTLE) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(SETTLE - 1);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through all inputs, samples each after a settle time and
// publishes the word with a done pulse. Optional parity output: MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_scan_sequencer_if.master bus
);
    localparam int N = 1 << SEL_W;

    scan_state_t      state, state_nxt;
    logic [SEL_W-1:0] sel_q;
    logic [N-1:0]     shadow_q;
    logic [N-1:0]     data_q;
    logic             busy_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             capture;
    logic             last_sel;
    logic [N-1:0]     word_done;

    settle_counter #(.SETTLE(SETTLE)) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    assign capture   = (state == S_WAIT) && cnt_zero;
    assign last_sel  = (sel_q == '1);
    assign word_done = {bus.mux_o, shadow_q[N-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_WAIT;
                    cnt_load  = 1'b1;
                end
            end
            S_WAIT: begin
                if (!cnt_zero)     cnt_dec   = 1'b1;
                else if (last_sel) state_nxt = S_DONE;
                else               cnt_load  = 1'b1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // sel is left at N-1 after a scan; only a new accept returns it to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                sel_q  <= '0;
                busy_q <= 1'b1;
            end
            if (capture) begin
                shadow_q[sel_q] <= bus.mux_o;
                if (last_sel) begin
                    data_q <= word_done;
                    busy_q <= 1'b0;
                end else begin
                    sel_q <= sel_q + 1'b1;
                end
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   parity_q <= 1'b0;
        else if (capture && last_sel) parity_q <= ~^word_done;
    end

    assign bus.parity = parity_q;
`endif

    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = (state == S_DONE);
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=1 and SETTLE=3) against a
// cycle-offset reference model; define MUX_SCAN_PARITY_EN to cover the parity output.
module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    localparam int SEL_W = 3;
    localparam int N     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] i_vec;

    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.SEL_W(SEL_W)) bus_a ();
    mux_scan_sequencer_if #(.SEL_W(SEL_W)) bus_b ();

    assign bus_a.start = start;
    assign bus_b.start = start;
    assign bus_a.mux_o = i_vec[bus_a.sel];
    assign bus_b.mux_o = i_vec[bus_b.sel];

    mux_scan_sequencer #(.SEL_W(SEL_W), .SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_scan_sequencer #(.SEL_W(SEL_W), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [SEL_W-1:0] o_sel  [2];
    logic             o_busy [2];
    logic             o_done [2];
    logic [7:0]       o_data [2];
    assign o_sel[0]  = bus_a.sel;      assign o_sel[1]  = bus_b.sel;
    assign o_busy[0] = bus_a.busy;     assign o_busy[1] = bus_b.busy;
    assign o_done[0] = bus_a.done;     assign o_done[1] = bus_b.done;
    assign o_data[0] = bus_a.data_out; assign o_data[1] = bus_b.data_out;
`ifdef MUX_SCAN_PARITY_EN
    logic o_par [2];
    assign o_par[0] = bus_a.parity;    assign o_par[1] = bus_b.parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 scanning, 2 done; j = edges since accept.
    int         m_settle [2] = '{1, 3};
    int         m_phase  [2];
    int         m_j      [2];
    int         m_sel    [2];
    logic [7:0] m_shadow [2];
    logic [7:0] m_data   [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_phase[m] = 0; m_j[m] = 0; m_sel[m] = 0;
            m_shadow[m] = '0; m_data[m] = '0;
        end
    endtask

    task automatic model_edge(input logic st, input logic [7:0] iv);
        for (int m = 0; m < 2; m++) begin
            int s;
            s = m_settle[m];
            case (m_phase[m])
                0: if (st) begin m_phase[m] = 1; m_j[m] = 0; m_sel[m] = 0; end
                1: begin
                    m_j[m]++;
                    if (m_j[m] % s == 0) m_shadow[m][m_j[m] / s - 1] = iv[m_j[m] / s - 1];
                    if (m_j[m] == N * s) begin
                        m_phase[m] = 2;
                        m_data[m]  = m_shadow[m];
                    end else begin
                        m_sel[m] = m_j[m] / s;
                    end
                end
                default: m_phase[m] = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("sel[%0d]", m),  32'(o_sel[m]),  32'(m_sel[m]));
            check($sformatf("busy[%0d]", m), 32'(o_busy[m]), 32'(m_phase[m] == 1));
            check($sformatf("done[%0d]", m), 32'(o_done[m]), 32'(m_phase[m] == 2));
            check($sformatf("data[%0d]", m), 32'(o_data[m]), 32'(m_data[m]));
`ifdef MUX_SCAN_PARITY_EN
            check($sformatf("parity[%0d]", m), 32'(o_par[m]), 32'(~^m_data[m]));
`endif
        end
    endtask

    task automatic step();
        logic       st, r;
        logic [7:0] iv;
        st = start; iv = i_vec; r = rst_n;
        @(posedge clk);
        if (r) model_edge(st, iv);
        else   model_reset();
        #1;
        compare_all();
    endtask

    task automatic drain(input int n);
        start = 1'b0;
        for (int c = 0; c < n; c++) step();
    endtask

    typedef struct {
        logic [7:0] i;
        int         dut;
        int         exp_cyc;
        logic [7:0] exp_word;
        logic       exp_par;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int         found, dcount, last_t;
        logic [7:0] tmp;
        int         done_t[$];

        tbl[0] = '{8'hA5, 0,  8, 8'hA5, 1'b1};
        tbl[1] = '{8'h3C, 1, 24, 8'h3C, 1'b1};
        tbl[2] = '{8'h81, 0,  8, 8'h81, 1'b1};
        tbl[3] = '{8'hFF, 1, 24, 8'hFF, 1'b1};
        tbl[4] = '{8'h01, 0,  8, 8'h01, 1'b0};

        rst_n = 1'b1; start = 1'b0; i_vec = 8'h00;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        step(); step();
        rst_n = 1'b1;
        step();

        // Table: one scan per vector, done latency and captured word
        for (int v = 0; v < 5; v++) begin
            i_vec = tbl[v].i;
            start = 1'b1;
            step();
            start = 1'b0;
            found = 0;
            for (int c = 1; c <= 40 && found == 0; c++) begin
                step();
                if (o_done[tbl[v].dut]) begin
                    found = 1;
                    check($sformatf("tbl%0d_done_cyc", v), 32'(c), 32'(tbl[v].exp_cyc));
                    check($sformatf("tbl%0d_word", v), 32'(o_data[tbl[v].dut]), 32'(tbl[v].exp_word));
`ifdef MUX_SCAN_PARITY_EN
                    check($sformatf("tbl%0d_parity", v), 32'(o_par[tbl[v].dut]), 32'(tbl[v].exp_par));
`endif
                end
            end
            if (found == 0) check($sformatf("tbl%0d_timeout", v), 32'(0), 32'(1));
            drain(30);
        end

        // Start re-pulsed at cycle 4 of a scan is ignored
        i_vec = 8'hFF; start = 1'b1; step(); start = 1'b0;
        dcount = 0;
        for (int c = 1; c <= 24; c++) begin
            start = (c == 4);
            step();
            if (o_done[0]) dcount++;
        end
        start = 1'b0;
        check("restart_done_count", 32'(dcount), 32'(1));
        check("restart_word", 32'(o_data[0]), 32'(8'hFF));
        drain(30);

        // Reset in the middle of a second scan
        i_vec = 8'h0F; start = 1'b1; step(); drain(30);
        check("pre_reset_word", 32'(o_data[0]), 32'(8'h0F));
        i_vec = 8'hF0; start = 1'b1; step(); start = 1'b0;
        for (int c = 1; c <= 5; c++) step();
        rst_n = 1'b0;
        #1;
        check("rst_sel",  32'(o_sel[0]),  32'(0));
        check("rst_busy", 32'(o_busy[0]), 32'(0));
        check("rst_done", 32'(o_done[0]), 32'(0));
        check("rst_data", 32'(o_data[0]), 32'(0));
        check("rst_data_b", 32'(o_data[1]), 32'(0));
        model_reset();
        step(); step();
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (o_done[0] || o_done[1]) dcount++;
        end
        check("post_reset_no_done", 32'(dcount), 32'(0));

        // Start held high: back-to-back scans every 10 cycles
        i_vec = 8'h81; start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            step();
            if (o_done[0]) begin
                done_t.push_back(c);
                check("held_word", 32'(o_data[0]), 32'(8'h81));
            end
        end
        start = 1'b0;
        check("held_done_count", 32'(done_t.size() >= 4), 32'(1));
        last_t = -1;
        foreach (done_t[k]) begin
            if (last_t >= 0) check("held_interval", 32'(done_t[k] - last_t), 32'(10));
            last_t = done_t[k];
        end
        drain(40);

        // Randomized start requests and mux inputs
        for (int c = 0; c < 400; c++) begin
            start = ($urandom_range(0, 3) == 0);
            tmp   = 8'($urandom);
            i_vec = tmp;
            step();
        end
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
